// File: rtl/sha_job_sequencer.sv
// Round-robin job sequencer that shares one sha core between NUM_REQ requesters.
// Each granted job walks the core through LOAD_TEXT -> HASH -> WRITE_RESULT,
// then closes the ACK handshake and reports done (or err on result timeout).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no owner; arbitrate among req_valid from the rr pointer
// S_LOAD   | LOAD_TEXT on the bus, counting memory->sha handshakes
// S_HASH   | HASH opcode held for HASH_HOLD cycles
// S_RESULT | WRITE_RESULT until first beat, then idle bus; count beats
// S_ACK    | sha_ack_ready high until the ack handshake completes
module sha_job_sequencer #(
  parameter int NUM_REQ   = 2,
  parameter int MSG_BYTES = 32,
  parameter int HASH_HOLD = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic [1:0]         opcode,
  output logic [1:0]         source_id,
  output logic [1:0]         dest_id,
  output logic               encdec,
  output logic [23:0]        addr,
  input  logic               sha_valid_in,
  input  logic               sha_ready_in,
  input  logic               sha_data_valid,
  input  logic               sha_ack_valid,
  output logic               sha_ack_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_LOAD_KEY  = 2'b00;
  localparam logic [1:0] OP_LOAD_TEXT = 2'b01;
  localparam logic [1:0] OP_RESULT    = 2'b10;
  localparam logic [1:0] OP_HASH      = 2'b11;
  localparam logic [1:0] ID_MEM       = 2'b00;
  localparam logic [1:0] ID_SHA       = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HASH,
    S_RESULT,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic [5:0]         cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               got_beat_q, got_beat_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               busy_q, busy_d;
  logic [1:0]         opcode_q, opcode_d;
  logic [1:0]         source_id_q, source_id_d;
  logic [1:0]         dest_id_q, dest_id_d;
  logic               ack_ready_q, ack_ready_d;

  logic               found;
  logic [1:0]         pick;
  logic [1:0]         next_ptr;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] grant_oh;

  assign next_ptr = (grant_id_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id_q + 2'd1;
  assign pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
  assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] && (((int'(rr_ptr_q) + i) % NUM_REQ) == j)) begin
          found = 1'b1;
          pick  = 2'(j);
        end
      end
    end
  end

  // Next-state logic; outputs are derived from the next state so they register with it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    got_beat_d  = got_beat_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    req_ready_d = '0;
    done_d      = '0;
    err_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_id_d  = pick;
          req_ready_d = pick_oh;
          cnt_d       = 6'(MSG_BYTES);
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (sha_valid_in && sha_ready_in) begin
          if (cnt_q == 6'd1) begin
            cnt_d   = 6'(HASH_HOLD);
            state_d = S_HASH;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      S_HASH: begin
        if (cnt_q == 6'd1) begin
          cnt_d      = 6'(MSG_BYTES);
          tmo_d      = TW'(TIMEOUT);
          got_beat_d = 1'b0;
          state_d    = S_RESULT;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_RESULT: begin
        if (sha_data_valid) begin
          got_beat_d = 1'b1;
          if (cnt_q == 6'd1) begin
            state_d = S_ACK;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end else if (!got_beat_q) begin
          if (tmo_q == TW'(1)) begin
            err_d    = grant_oh;
            rr_ptr_d = next_ptr;
            state_d  = S_IDLE;
          end else begin
            tmo_d = tmo_q - TW'(1);
          end
        end
      end
      S_ACK: begin
        if (sha_ack_valid && ack_ready_q) begin
          done_d   = grant_oh;
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    ack_ready_d = (state_d == S_ACK);
    opcode_d    = OP_LOAD_KEY;
    source_id_d = ID_MEM;
    dest_id_d   = ID_MEM;
    case (state_d)
      S_LOAD: begin
        opcode_d  = OP_LOAD_TEXT;
        dest_id_d = ID_SHA;
      end
      S_HASH: begin
        opcode_d  = OP_HASH;
        dest_id_d = ID_SHA;
      end
      S_RESULT: begin
        // Once the core starts returning data, park the bus so it cannot restart TX.
        if (!got_beat_d) begin
          opcode_d    = OP_RESULT;
          source_id_d = ID_SHA;
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs; reset mid-job drops straight back to idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      got_beat_q  <= 1'b0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      req_ready_q <= '0;
      done_q      <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      opcode_q    <= OP_LOAD_KEY;
      source_id_q <= ID_MEM;
      dest_id_q   <= ID_MEM;
      ack_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      got_beat_q  <= got_beat_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      opcode_q    <= opcode_d;
      source_id_q <= source_id_d;
      dest_id_q   <= dest_id_d;
      ack_ready_q <= ack_ready_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign done          = done_q;
  assign err           = err_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
  assign opcode        = opcode_q;
  assign source_id     = source_id_q;
  assign dest_id       = dest_id_q;
  assign sha_ack_ready = ack_ready_q;
  assign encdec        = 1'b0;
  assign addr          = 24'd0;

endmodule

// File: tb/tb_sha_job_sequencer.sv
// Self-checking bench for sha_job_sequencer: a round-robin owner model plus
// per-phase transaction checks (beat counts, hold lengths, timeout, pulses).
module tb_sha_job_sequencer;

  localparam int N       = 2;
  localparam int MSG     = 32;
  localparam int HOLD    = 4;
  localparam int TMO     = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready, done, err;
  logic [1:0]    grant_id, opcode, source_id, dest_id;
  logic          busy, encdec, sha_ack_ready;
  logic [23:0]   addr;
  logic          sha_valid_in = 1'b0;
  logic          sha_ready_in = 1'b0;
  logic          sha_data_valid = 1'b0;
  logic          sha_ack_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  int ptr_m = 0;
  bit keep = 1'b0;

  sha_job_sequencer #(.NUM_REQ(N), .MSG_BYTES(MSG), .HASH_HOLD(HOLD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .done(done), .err(err), .grant_id(grant_id), .busy(busy), .opcode(opcode),
    .source_id(source_id), .dest_id(dest_id), .encdec(encdec), .addr(addr),
    .sha_valid_in(sha_valid_in), .sha_ready_in(sha_ready_in),
    .sha_data_valid(sha_data_valid), .sha_ack_valid(sha_ack_valid),
    .sha_ack_ready(sha_ack_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] rv, input int p);
    for (int i = 0; i < N; i++) begin
      if (rv[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    sha_valid_in = 0; sha_ready_in = 0; sha_data_valid = 0; sha_ack_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (busy !== 1'b0 || req_ready !== '0 || done !== '0 || err !== '0) begin
      failures++;
      $display("FAIL %s_flags busy=%b req_ready=%b done=%b err=%b expected all 0", tag, busy, req_ready, done, err);
    end
    checks++;
    if (grant_id !== 2'd0) begin
      failures++;
      $display("FAIL %s_grant got=%0d expected=0", tag, grant_id);
    end
    checks++;
    if ({opcode, source_id, dest_id} !== 6'b0) begin
      failures++;
      $display("FAIL %s_bus got=%b_%b_%b expected=00_00_00", tag, opcode, source_id, dest_id);
    end
    checks++;
    if (sha_ack_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_ack_ready got=%b expected=0", tag, sha_ack_ready);
    end
  endtask

  // Full job: grant, LOAD, HASH, RESULT (normal or timeout), ACK.
  task automatic run_job(input int ready_mode, input bit timeout, input int ack_delay);
    int owner, n, hs, pulses, d, bad;
    bit got, sv, sr, dv;
    owner = rr_pick(req_valid, ptr_m);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready !== '0) begin got = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL grant_wait no req_ready within 20 cycles expected owner=%0d", owner);
      return;
    end
    checks++;
    if (req_ready !== oh(owner) || grant_id !== 2'(owner) || busy !== 1'b1) begin
      failures++;
      $display("FAIL grant req_ready=%b grant_id=%0d busy=%b expected req_ready=%b grant_id=%0d busy=1",
               req_ready, grant_id, busy, oh(owner), owner);
    end
    if (!keep) req_valid[owner] = 1'b0;

    // LOAD
    hs = 0; n = 0; bad = 0;
    while (opcode === 2'b01 && hs < MSG && n < 400) begin
      if (source_id !== 2'b00 || dest_id !== 2'b01) bad++;
      if (ready_mode == 1) begin
        sv = 1'b1;
        sr = (n % 2 == 1);
      end else begin
        sv = ($urandom % 4) != 0;
        sr = ($urandom % 4) != 0;
      end
      sha_valid_in = sv; sha_ready_in = sr;
      if (sv && sr) hs++;
      n++;
      @(negedge clk);
    end
    sha_valid_in = 0; sha_ready_in = 0;
    checks++;
    if (bad != 0 || hs != MSG) begin
      failures++;
      $display("FAIL load_beats handshakes=%0d bad_bus_cycles=%0d expected %0d handshakes, 0 bad", hs, bad, MSG);
    end
    checks++;
    if ({opcode, source_id, dest_id} !== 6'b11_00_01) begin
      failures++;
      $display("FAIL hash_entry bus=%b_%b_%b expected=11_00_01", opcode, source_id, dest_id);
    end

    // HASH
    n = 0;
    while ({opcode, source_id, dest_id} === 6'b11_00_01 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != HOLD || {opcode, source_id, dest_id} !== 6'b10_01_00) begin
      failures++;
      $display("FAIL hash_hold cycles=%0d then bus=%b_%b_%b expected %0d cycles then 10_01_00",
               n, opcode, source_id, dest_id, HOLD);
    end

    if (timeout) begin
      n = 0;
      while (opcode === 2'b10 && n < TMO + 50) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n != TMO) begin
        failures++;
        $display("FAIL timeout_len result_cycles=%0d expected=%0d", n, TMO);
      end
      checks++;
      if (err !== oh(owner) || done !== '0 || busy !== 1'b0 || {opcode, source_id, dest_id} !== 6'b0) begin
        failures++;
        $display("FAIL timeout_err err=%b done=%b busy=%b bus=%b_%b_%b expected err=%b done=0 busy=0 bus idle",
                 err, done, busy, opcode, source_id, dest_id, oh(owner));
      end
      ptr_m = (owner + 1) % N;
      @(negedge clk);
      checks++;
      if (err !== '0) begin
        failures++;
        $display("FAIL err_pulse err=%b expected=0", err);
      end
      return;
    end

    // RESULT
    d = $urandom_range(0, 5);
    pulses = 0; n = 0; bad = 0;
    while (pulses < MSG && n < 400) begin
      if (pulses == 0 && {opcode, source_id, dest_id} !== 6'b10_01_00) bad++;
      if (pulses > 0 && {opcode, source_id, dest_id} !== 6'b0) bad++;
      if (sha_ack_ready !== 1'b0) bad++;
      dv = (n >= d) && (($urandom % 3) != 0);
      sha_data_valid = dv;
      if (dv) pulses++;
      n++;
      @(negedge clk);
    end
    sha_data_valid = 0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL result_bus bad_cycles=%0d expected=0", bad);
    end
    checks++;
    if (sha_ack_ready !== 1'b1 || busy !== 1'b1 || {opcode, source_id, dest_id} !== 6'b0) begin
      failures++;
      $display("FAIL ack_entry ack_ready=%b busy=%b bus=%b_%b_%b expected 1,1,idle after %0d beats",
               sha_ack_ready, busy, opcode, source_id, dest_id, pulses);
    end

    // ACK
    bad = 0;
    for (int i = 0; i < ack_delay; i++) begin
      if (sha_ack_ready !== 1'b1 || done !== '0) bad++;
      sha_ack_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || sha_ack_ready !== 1'b1) begin
      failures++;
      $display("FAIL ack_hold bad_cycles=%0d ack_ready=%b expected 0 bad and ack_ready=1", bad, sha_ack_ready);
    end
    sha_ack_valid = 1'b1;
    @(negedge clk);
    sha_ack_valid = 1'b0;
    checks++;
    if (done !== oh(owner) || err !== '0 || sha_ack_ready !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL done done=%b err=%b ack_ready=%b busy=%b req_ready=%b expected done=%b others 0",
               done, err, sha_ack_ready, busy, req_ready, oh(owner));
    end
    ptr_m = (owner + 1) % N;
    @(negedge clk);
    checks++;
    if (done !== '0) begin
      failures++;
      $display("FAIL done_pulse done=%b expected=0", done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset");
    checks++;
    if (encdec !== 1'b0 || addr !== 24'd0) begin
      failures++;
      $display("FAIL tie_offs encdec=%b addr=%h expected 0", encdec, addr);
    end
  endtask

  task automatic test_single();
    keep = 0;
    req_valid = 2'b01;
    run_job(0, 1'b0, 2);
  endtask

  task automatic test_round_robin();
    do_reset();
    keep = 1;
    req_valid = 2'b11;
    run_job(0, 1'b0, 1);
    run_job(0, 1'b0, 0);
    keep = 0;
    req_valid = 2'b01;
    run_job(0, 1'b0, 3);
  endtask

  task automatic test_toggle_ready();
    keep = 0;
    req_valid = 2'b01;
    run_job(1, 1'b0, 1);
  endtask

  task automatic test_timeout();
    do_reset();
    keep = 0;
    req_valid = 2'b01;
    run_job(0, 1'b1, 0);
    req_valid = 2'b11;
    run_job(0, 1'b0, 1);
    req_valid = '0;
  endtask

  task automatic test_ack_hold();
    keep = 0;
    req_valid = 2'b01;
    run_job(0, 1'b0, 20);
  endtask

  task automatic test_reset_mid();
    bit got;
    do_reset();
    keep = 0;
    req_valid = 2'b10;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready !== '0) begin got = 1; break; end
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (!got || grant_id !== 2'(rr_pick(2'b10, ptr_m))) begin
      failures++;
      $display("FAIL midreset_grant got=%b grant_id=%0d expected grant_id=%0d", got, grant_id, rr_pick(2'b10, ptr_m));
    end
    for (int i = 0; i < 10; i++) begin
      sha_valid_in = 1; sha_ready_in = 1;
      @(negedge clk);
    end
    sha_valid_in = 0; sha_ready_in = 0;
    checks++;
    if (opcode !== 2'b01) begin
      failures++;
      $display("FAIL midreset_load opcode=%b expected=01 after 10 beats", opcode);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    req_valid = 2'b01;
    run_job(0, 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_toggle_ready();
    test_timeout();
    test_ack_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule
